// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encoding and baud-divider helpers.
package fifo_uart_tx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Clocks per bit, truncated.
    function automatic int baud_div(input int freq_hz, input int bauds);
        return freq_hz / bauds;
    endfunction

    // Bits needed to count 0..div-1.
    function automatic int baud_cnt_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tx_fifo_buf.sv
// Circular byte buffer with occupancy count, full flag, free-entry count and
// a registered overflow pulse for writes that arrive while full.
module tx_fifo_buf
    import fifo_uart_tx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [BYTE_W-1:0]     push_data,
    input  logic                  pop,
    output logic [BYTE_W-1:0]     head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   bytes_free,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [BYTE_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    // push/pop are single-cycle strobes; a push is accepted only when the
    // registered count is below DEPTH, a pop only when it is non-zero.
    assign full       = (count == DEPTH_CNT);
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign head       = mem[rd_ptr];
    assign bytes_free = DEPTH_CNT - count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            overflow <= push && full;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Buffered 8N1 UART transmitter: bytes queue in tx_fifo_buf and are sent
// LSB-first, starting a new frame only while the synchronized CTS is high.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int FREQ_HZ    = 10000000,
    parameter int BAUDS      = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [7:0]          tx_data,
    input  logic                peer_cts,
    output logic                tx,
    output logic                full,
    output logic                busy,
    output logic [DEPTH_LOG2:0] bytes_free,
    output logic                overflow
);

    localparam int DIV   = baud_div(FREQ_HZ, BAUDS);
    localparam int CNT_W = baud_cnt_width(DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("fifo_uart_tx: FREQ_HZ/BAUDS must be at least 2");
        end
    endgenerate

    tx_state_t         state, state_n;
    logic [CNT_W-1:0]  baud_cnt, baud_cnt_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [7:0]        shift, shift_n;
    logic              tx_reg, tx_n;
    logic              cts_meta, cts_s;
    logic              pop;
    logic              fifo_empty;
    logic [7:0]        head;
    logic              bit_end;

    tx_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (wr),
        .push_data  (tx_data),
        .pop        (pop),
        .head       (head),
        .empty      (fifo_empty),
        .full       (full),
        .bytes_free (bytes_free),
        .overflow   (overflow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cts_meta <= 1'b0;
            cts_s    <= 1'b0;
        end else begin
            cts_meta <= peer_cts;
            cts_s    <= cts_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_reg   <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx_reg   <= tx_n;
        end
    end

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && cts_s) begin
                    pop        = 1'b1;
                    shift_n    = head;
                    baud_cnt_n = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    shift_n    = {1'b0, shift[7:1]};
                    bit_idx_n  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end else begin
                    baud_cnt_n = baud_cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    // CTS is only honoured here and in IDLE, so frames never split.
                    if (!fifo_empty && cts_s) begin
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is registered from the next state so tx is glitch-free.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    assign tx   = tx_reg;
    assign busy = !fifo_empty || (state != IDLE);

endmodule
